// File: rtl/pcileech_cfgshadow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_cfgshadow_pkg
// Description : Shared types, dword indices and write-mask helper for the
//               multi-function configuration-space shadow.
// Revision    : 1.0 - initial release
// ============================================================================
package pcileech_cfgshadow_pkg;

  // Request sequencer states
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Header dword indices
  localparam int DW_ID       = 0;
  localparam int DW_CMD      = 1;
  localparam int DW_CLASS    = 2;
  localparam int DW_HDR      = 3;
  localparam int DW_BAR0     = 4;
  localparam int DW_SUBSYS   = 11;
  localparam int DW_INTLINE  = 15;
  localparam int DW_SCRATCH0 = 16;

  // Writable bits of a dword; everything else in the header is read-only.
  function automatic logic [31:0] wfmask(input int dw, input int bar_size_log2);
    logic [31:0] m;
    m = 32'h0000_0000;
    if (dw >= DW_SCRATCH0) begin
      m = 32'hFFFF_FFFF;
    end else if (dw == DW_CMD) begin
      m = 32'h0000_0407;
    end else if (dw == DW_BAR0) begin
      m = 32'hFFFF_FFFF << bar_size_log2;
    end else if (dw == DW_INTLINE) begin
      m = 32'h0000_00FF;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_int_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_int_rr_arb
// Description : Round-robin arbiter over per-function pending interrupts.
//               A grant is held stable until acknowledged; the pointer then
//               moves just past the granted function.
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_int_rr_arb #(
  parameter int NUM_FUNC = 2
) (
  input  logic                clk_pcie,
  input  logic                rst,
  input  logic [NUM_FUNC-1:0] i_pend,
  input  logic                i_ack,
  output logic                o_valid,
  output logic [2:0]          o_func
);

  logic       r_valid;
  logic [2:0] r_func;
  logic [2:0] r_ptr;
  logic       w_found;
  logic [2:0] w_pick;
  logic [2:0] w_ptr_nxt;

  // Pick the first pending function at or after the pointer, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int c = 0; c < NUM_FUNC; c++) begin
      if (!w_found && i_pend[c] && (c >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_pick  = 3'(c);
      end
    end
    for (int c = 0; c < NUM_FUNC; c++) begin
      if (!w_found && i_pend[c] && (c < int'(r_ptr))) begin
        w_found = 1'b1;
        w_pick  = 3'(c);
      end
    end
  end

  assign w_ptr_nxt = (int'(r_func) >= NUM_FUNC - 1) ? 3'd0 : (r_func + 3'd1);

  // Grant register: load on a free slot, hold until the core acknowledges
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_func  <= 3'd0;
      r_ptr   <= 3'd0;
    end else if (r_valid) begin
      if (i_ack) begin
        r_valid <= 1'b0;
        r_ptr   <= w_ptr_nxt;
      end
    end else if (w_found) begin
      r_valid <= 1'b1;
      r_func  <= w_pick;
    end
  end

  assign o_valid = r_valid;
  assign o_func  = r_func;

endmodule
`default_nettype wire

// File: rtl/pcileech_cfgshadow_mf.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_cfgshadow_mf
// Description : Multi-function PCIe configuration-space shadow. Serves dword
//               reads/writes per function with write masks, BAR0 sizing,
//               command register and round-robin legacy interrupt delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_cfgshadow_mf
  import pcileech_cfgshadow_pkg::*;
#(
  parameter int          NUM_FUNC      = 2,
  parameter int          NUM_DW        = 64,
  parameter int          BAR_SIZE_LOG2 = 12,
  parameter logic [15:0] VENDOR_ID     = 16'h10EE,
  parameter logic [15:0] DEVICE_ID     = 16'h0666
) (
  input  logic                      clk_pcie,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [2:0]                req_func,
  input  logic [$clog2(NUM_DW)-1:0] req_dw,
  input  logic [3:0]                req_be,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic                      rsp_ur,
  output logic [32*NUM_FUNC-1:0]    bar_base,
  output logic [NUM_FUNC-1:0]       mem_en,
  input  logic [NUM_FUNC-1:0]       int_req,
  output logic                      int_valid,
  output logic [2:0]                int_func,
  input  logic                      int_ack
);

  localparam int         DWW       = $clog2(NUM_DW);
  localparam int         SCR_PER_F = NUM_DW - DW_SCRATCH0;
  localparam int         RAM_DEPTH = NUM_FUNC * SCR_PER_F;
  localparam int         RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [7:0] HDR_TYPE  = (NUM_FUNC > 1) ? 8'h80 : 8'h00;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_init_we;
  logic                w_access;

  logic                r_wr;
  logic [2:0]          r_func;
  logic [DWW-1:0]      r_dw;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_ur;
  logic [RAM_AW-1:0]   r_init_cnt;

  logic [31:0]         r_ram [RAM_DEPTH];
  logic [31:0]         r_cmd [NUM_FUNC];
  logic [31:0]         r_bar [NUM_FUNC];
  logic [7:0]          r_intline [NUM_FUNC];
  logic [NUM_FUNC-1:0] r_pend;

  logic                w_func_ok;
  logic                w_is_scr;
  logic [31:0]         w_bemask;
  logic [31:0]         w_wmask;
  logic [RAM_AW-1:0]   w_ram_idx;
  logic [31:0]         w_ram_rd;
  logic                w_ram_we;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [31:0]         w_ram_wdata;
  logic [31:0]         w_cmd_sel;
  logic [31:0]         w_bar_sel;
  logic [7:0]          w_il_sel;
  logic                w_pend_sel;
  logic [31:0]         w_id;
  logic [31:0]         w_hdr_rd;
  logic [31:0]         w_rd_data;
  logic                w_ack_fire;

  // State register
  always_ff @(posedge clk_pcie) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_init_we   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_init_cnt == RAM_AW'(RAM_DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_access    = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Scratch clear sweep counter, restarted by every reset
  always_ff @(posedge clk_pcie) begin
    if (rst)            r_init_cnt <= '0;
    else if (w_init_we) r_init_cnt <= r_init_cnt + RAM_AW'(1);
  end

  // Capture the accepted request for the access cycle
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_func  <= 3'd0;
      r_dw    <= '0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
    end else if (req_ready && req_valid) begin
      r_wr    <= req_wr;
      r_func  <= req_func;
      r_dw    <= req_dw;
      r_be    <= req_be;
      r_wdata <= req_wdata;
    end
  end

  assign w_func_ok = (int'(r_func) < NUM_FUNC);
  assign w_is_scr  = (int'(r_dw) >= DW_SCRATCH0);
  assign w_bemask  = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
  assign w_wmask   = wfmask(int'(r_dw), BAR_SIZE_LOG2) & w_bemask;
  assign w_ram_idx = RAM_AW'(int'(r_func) * SCR_PER_F + int'(r_dw) - DW_SCRATCH0);
  assign w_ram_rd  = r_ram[w_ram_idx];

  // Single RAM write port shared by the clear sweep and scratch writes
  assign w_ram_we    = w_init_we | (w_access & r_wr & w_func_ok & w_is_scr);
  assign w_ram_addr  = w_init_we ? r_init_cnt : w_ram_idx;
  assign w_ram_wdata = w_init_we ? 32'h0 : ((w_ram_rd & ~w_wmask) | (r_wdata & w_wmask));

  // Scratch RAM storage
  always_ff @(posedge clk_pcie) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
  end

  // Select the addressed function's header registers
  always_comb begin
    w_cmd_sel  = 32'h0;
    w_bar_sel  = 32'h0;
    w_il_sel   = 8'h0;
    w_pend_sel = 1'b0;
    for (int f = 0; f < NUM_FUNC; f++) begin
      if (int'(r_func) == f) begin
        w_cmd_sel  = r_cmd[f];
        w_bar_sel  = r_bar[f];
        w_il_sel   = r_intline[f];
        w_pend_sel = r_pend[f];
      end
    end
  end

  assign w_id = {DEVICE_ID + 16'(r_func), VENDOR_ID};

  // Header read mux; interrupt status lives in status bit 3 (dword bit 19)
  always_comb begin
    w_hdr_rd = 32'h0;
    case (r_dw)
      DWW'(DW_ID):      w_hdr_rd = w_id;
      DWW'(DW_CMD):     w_hdr_rd = {12'h0, w_pend_sel, 19'h0} | (w_cmd_sel & 32'h0000_0407);
      DWW'(DW_CLASS):   w_hdr_rd = 32'h0200_0000;
      DWW'(DW_HDR):     w_hdr_rd = {8'h00, HDR_TYPE, 16'h0000};
      DWW'(DW_BAR0):    w_hdr_rd = w_bar_sel;
      DWW'(DW_SUBSYS):  w_hdr_rd = w_id;
      DWW'(DW_INTLINE): w_hdr_rd = {16'h0000, 8'h01, w_il_sel};
      default:          w_hdr_rd = 32'h0;
    endcase
  end

  assign w_rd_data = !w_func_ok ? 32'hFFFF_FFFF : (w_is_scr ? w_ram_rd : w_hdr_rd);

  // Response register, stable for the whole RESP phase
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      r_rsp_data <= 32'h0;
      r_rsp_ur   <= 1'b0;
    end else if (w_access) begin
      r_rsp_ur   <= !w_func_ok;
      r_rsp_data <= r_wr ? 32'h0 : w_rd_data;
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_ur   = r_rsp_ur;

  // Writable header fields, byte-enabled and field-masked
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      for (int f = 0; f < NUM_FUNC; f++) begin
        r_cmd[f]     <= 32'h0;
        r_bar[f]     <= 32'h0;
        r_intline[f] <= 8'h0;
      end
    end else if (w_access && r_wr && w_func_ok) begin
      for (int f = 0; f < NUM_FUNC; f++) begin
        if (int'(r_func) == f) begin
          if (r_dw == DWW'(DW_CMD))
            r_cmd[f] <= (r_cmd[f] & ~w_wmask) | (r_wdata & w_wmask);
          if (r_dw == DWW'(DW_BAR0))
            r_bar[f] <= (r_bar[f] & ~w_wmask) | (r_wdata & w_wmask);
          if (r_dw == DWW'(DW_INTLINE))
            r_intline[f] <= (r_intline[f] & ~w_wmask[7:0]) | (r_wdata[7:0] & w_wmask[7:0]);
        end
      end
    end
  end

  assign w_ack_fire = int_valid & int_ack;

  // Pending latches: set by level request, cleared by ack (unless re-armed)
  // and forced clear while the interrupt-disable bit is set
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      for (int f = 0; f < NUM_FUNC; f++) begin
        r_pend[f] <= !r_cmd[f][10] &
                     (int_req[f] | (r_pend[f] & !(w_ack_fire && (int'(int_func) == f))));
      end
    end
  end

  pcileech_int_rr_arb #(
    .NUM_FUNC (NUM_FUNC)
  ) u_int_arb (
    .clk_pcie (clk_pcie),
    .rst      (rst),
    .i_pend   (r_pend),
    .i_ack    (int_ack),
    .o_valid  (int_valid),
    .o_func   (int_func)
  );

  generate
    for (genvar f = 0; f < NUM_FUNC; f++) begin : g_func_out
      assign bar_base[32*f +: 32] = r_bar[f];
      assign mem_en[f]            = r_cmd[f][1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pcileech_cfgshadow_mf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcileech_cfgshadow_mf
// Description : Directed self-checking bench for pcileech_cfgshadow_mf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcileech_cfgshadow_mf;

  logic        clk_pcie;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_func;
  logic [5:0]  req_dw;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ur;
  logic [63:0] bar_base;
  logic [1:0]  mem_en;
  logic [1:0]  int_req;
  logic        int_valid;
  logic [2:0]  int_func;
  logic        int_ack;

  int n_tests = 0;
  int n_fail  = 0;

  pcileech_cfgshadow_mf dut (
    .clk_pcie  (clk_pcie),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_func  (req_func),
    .req_dw    (req_dw),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ur    (rsp_ur),
    .bar_base  (bar_base),
    .mem_en    (mem_en),
    .int_req   (int_req),
    .int_valid (int_valid),
    .int_func  (int_func),
    .int_ack   (int_ack)
  );

  initial clk_pcie = 1'b0;
  always #5 clk_pcie = ~clk_pcie;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response transaction; called and returns on a falling edge
  task automatic do_req(input logic wr, input logic [2:0] fn, input logic [5:0] dw,
                        input logic [3:0] be, input logic [31:0] wd, input int hold,
                        input logic [31:0] hold_exp,
                        output logic [31:0] data, output logic ur, output int lat);
    int g;
    req_wr = wr; req_func = fn; req_dw = dw; req_be = be; req_wdata = wd;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 300) begin @(negedge clk_pcie); g++; end
    if (!req_ready) chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(negedge clk_pcie);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk_pcie); lat++; end
    if (!rsp_valid) chk("rsp_valid_wait", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_pcie);
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_data", rsp_data, hold_exp);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    data = rsp_data;
    ur   = rsp_ur;
    rsp_ready = 1'b1;
    @(negedge clk_pcie);
    rsp_ready = 1'b0;
  endtask

  // Release reset and count cycles until the scratch sweep finishes
  task automatic release_and_count(output int cyc);
    rst = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 1000) begin @(negedge clk_pcie); cyc++; end
  endtask

  // Wait for an interrupt grant, check its function, then acknowledge it
  task automatic grant(input string tag, input logic [2:0] exp_f);
    int g;
    g = 0;
    while (!int_valid && g < 50) begin @(negedge clk_pcie); g++; end
    chk({tag, "_valid"}, {31'b0, int_valid}, 32'd1);
    chk(tag, {29'b0, int_func}, {29'b0, exp_f});
    int_ack = 1'b1;
    @(negedge clk_pcie);
    int_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        u;
    int          lat;
    int          cyc;
    int          g;

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_func = 3'd0; req_dw = 6'd0;
    req_be = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b0; int_req = 2'b00; int_ack = 1'b0;
    repeat (3) @(negedge clk_pcie);

    // Reset state
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_int_valid", {31'b0, int_valid}, 32'd0);
    chk("rst_int_func", {29'b0, int_func}, 32'd0);
    chk("rst_bar_lo", bar_base[31:0], 32'h0);
    chk("rst_mem_en", {30'b0, mem_en}, 32'd0);

    release_and_count(cyc);
    chk("init_cycles", cyc, 32'd96);

    do_req(1'b0, 3'd1, 6'd20, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw20_init", d, 32'h0);

    // Identification and fixed header fields
    do_req(1'b0, 3'd1, 6'd0, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw0", d, 32'h0667_10EE);
    chk("f1_dw0_lat", lat, 32'd2);
    chk("f1_dw0_ur", {31'b0, u}, 32'd0);
    do_req(1'b0, 3'd0, 6'd3, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f0_dw3", d, 32'h0080_0000);
    do_req(1'b0, 3'd0, 6'd2, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f0_dw2", d, 32'h0200_0000);
    do_req(1'b0, 3'd1, 6'd11, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw11", d, 32'h0667_10EE);
    do_req(1'b0, 3'd1, 6'd15, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw15", d, 32'h0000_0100);

    // BAR0 sizing and base programming
    do_req(1'b1, 3'd0, 6'd4, 4'hF, 32'hFFFF_FFFF, 0, 32'h0, d, u, lat);
    chk("bar_wr_rsp", d, 32'h0);
    chk("bar_wr_ur", {31'b0, u}, 32'd0);
    do_req(1'b0, 3'd0, 6'd4, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("bar_size", d, 32'hFFFF_F000);
    do_req(1'b1, 3'd0, 6'd4, 4'hF, 32'hF700_1234, 0, 32'h0, d, u, lat);
    chk("bar_base_f0", bar_base[31:0], 32'hF700_1000);
    chk("bar_base_f1", bar_base[63:32], 32'h0);

    // Command register and byte enables
    do_req(1'b1, 3'd1, 6'd1, 4'h1, 32'h0000_0006, 0, 32'h0, d, u, lat);
    chk("mem_en_set", {30'b0, mem_en}, 32'd2);
    do_req(1'b1, 3'd1, 6'd1, 4'h0, 32'h0000_0000, 0, 32'h0, d, u, lat);
    chk("mem_en_be0", {30'b0, mem_en}, 32'd2);
    do_req(1'b0, 3'd1, 6'd1, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw1", d, 32'h0000_0006);
    do_req(1'b1, 3'd1, 6'd0, 4'hF, 32'h1234_5678, 0, 32'h0, d, u, lat);
    do_req(1'b0, 3'd1, 6'd0, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw0_ro", d, 32'h0667_10EE);

    // Unsupported function, with a back-pressured response
    do_req(1'b0, 3'd5, 6'd0, 4'hF, 32'h0, 5, 32'hFFFF_FFFF, d, u, lat);
    chk("f5_rd", d, 32'hFFFF_FFFF);
    chk("f5_rd_ur", {31'b0, u}, 32'd1);
    do_req(1'b1, 3'd5, 6'd4, 4'hF, 32'hFFFF_FFFF, 0, 32'h0, d, u, lat);
    chk("f5_wr_data", d, 32'h0);
    chk("f5_wr_ur", {31'b0, u}, 32'd1);
    chk("f5_wr_bar", bar_base[31:0], 32'hF700_1000);

    // Scratch RAM with partial byte enables
    do_req(1'b1, 3'd0, 6'd20, 4'b0101, 32'hDEAD_BEEF, 0, 32'h0, d, u, lat);
    do_req(1'b0, 3'd0, 6'd20, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("scr_be0101", d, 32'h00AD_00EF);
    do_req(1'b1, 3'd0, 6'd20, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, d, u, lat);
    do_req(1'b0, 3'd0, 6'd20, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("scr_full", d, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd1, 6'd20, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("scr_f1_iso", d, 32'h0);

    // Interrupt round robin
    int_req = 2'b11;
    grant("irq_g0", 3'd0);
    grant("irq_g1", 3'd1);
    grant("irq_g2", 3'd0);

    // Disable interrupts on function 1; a grant already shown is drained
    do_req(1'b1, 3'd1, 6'd1, 4'h3, 32'h0000_0406, 0, 32'h0, d, u, lat);
    chk("mem_en_keep", {30'b0, mem_en}, 32'd2);
    repeat (3) @(negedge clk_pcie);
    if (int_valid) begin
      int_ack = 1'b1;
      @(negedge clk_pcie);
      int_ack = 1'b0;
    end
    grant("irq_dis0", 3'd0);
    grant("irq_dis1", 3'd0);
    grant("irq_dis2", 3'd0);
    do_req(1'b0, 3'd1, 6'd1, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f1_dw1_dis", d, 32'h0000_0406);
    do_req(1'b0, 3'd0, 6'd1, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("f0_dw1_stat", d, 32'h0008_0000);
    int_req = 2'b00;

    // Reset while a response is waiting
    req_wr = 1'b0; req_func = 3'd0; req_dw = 6'd20; req_be = 4'hF; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk_pcie); g++; end
    @(negedge clk_pcie);
    req_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk_pcie); g++; end
    chk("midrst_pre", rsp_data, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk_pcie);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    chk("midrst_int_valid", {31'b0, int_valid}, 32'd0);
    chk("midrst_mem_en", {30'b0, mem_en}, 32'd0);
    release_and_count(cyc);
    chk("midrst_init_cycles", cyc, 32'd96);
    do_req(1'b0, 3'd0, 6'd20, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("midrst_scr", d, 32'h0);
    do_req(1'b0, 3'd0, 6'd4, 4'hF, 32'h0, 0, 32'h0, d, u, lat);
    chk("midrst_bar", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
